stream_demux_router: RTL and testbench

//  Packet-granular 1-to-N stream demultiplexer: the distribution side of our N-to-1 select muxes.
//  - The head beat of each packet carries a destination address.
//  - Every beat of that packet is routed to one of N_OUT output streams, each through a 1-deep register slice.
//  - Sits between a single producer and several consumer datapaths. Valid/ready handshake on every port.

---
 rtl/stream_demux_router.sv | 120 ++++++++++++
 tb/tb_stream_demux_router.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_router.sv
// Packet-granular 1-to-N stream demultiplexer. The head beat's address picks the output,
// and every beat of that packet goes there through a 1-deep register slice per output.
module stream_demux_router #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned N_OUT  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_last,
   input  logic [ADDR_W-1:0]        in_addr,
   output logic [N_OUT-1:0]         out_valid,
   input  logic [N_OUT-1:0]         out_ready,
   output logic [N_OUT*WIDTH-1:0]   out_data,
   output logic [N_OUT-1:0]         out_last,
   output logic                     busy,
   output logic [7:0]               drop_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUTE = 2'd1,
      DROP  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] NUM_OUT = (ADDR_W+1)'(N_OUT);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   sel, sel_nxt, target;
   logic                addr_ok, target_free, route_en, drop_inc;
   logic [N_OUT-1:0]    free, load;

   // A slot can take a beat when empty or draining this cycle, so in_ready never looks at in_valid.
   always_comb begin
      addr_ok     = ({1'b0, in_addr} < NUM_OUT);
      free        = ~out_valid | out_ready;
      target      = (state == ROUTE) ? sel : in_addr;
      target_free = 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         if (target == ADDR_W'(k)) target_free = free[k];
      end

      state_nxt = state;
      sel_nxt   = sel;
      in_ready  = 1'b0;
      route_en  = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = addr_ok ? target_free : 1'b1;
            if (in_valid && in_ready) begin
               if (addr_ok) begin
                  route_en = 1'b1;
                  if (!in_last) begin
                     state_nxt = ROUTE;
                     sel_nxt   = in_addr;
                  end
               end else begin
                  drop_inc = 1'b1;
                  if (!in_last) state_nxt = DROP;
               end
            end
         end
         ROUTE: begin
            in_ready = target_free;
            if (in_valid && in_ready) begin
               route_en = 1'b1;
               if (in_last) state_nxt = IDLE;
            end
         end
         DROP: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      load = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         if (route_en && target == ADDR_W'(k)) load[k] = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= '0;
         drop_count <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end

   // Load wins over drain so a full slot can pass one beat per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_data  <= '0;
         out_last  <= '0;
      end else begin
         for (int unsigned k = 0; k < N_OUT; k++) begin
            if (load[k]) begin
               out_valid[k]                <= 1'b1;
               out_data[k*WIDTH +: WIDTH]  <= in_data;
               out_last[k]                 <= in_last;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_demux_router.sv
// Directed bench for stream_demux_router: a 4-output instance for routing/stall/reset
// and a 3-output instance for bad-address dropping and counter saturation.
module tb_stream_demux_router;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, in_last, busy;
   logic [7:0]  in_data, drop_count;
   logic [1:0]  in_addr;
   logic [3:0]  out_valid, out_ready, out_last;
   logic [31:0] out_data;

   logic        b_in_valid, b_in_ready, b_in_last, b_busy;
   logic [7:0]  b_in_data, b_drop_count;
   logic [1:0]  b_in_addr;
   logic [2:0]  b_out_valid, b_out_ready, b_out_last;
   logic [23:0] b_out_data;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   stream_demux_router #(.WIDTH(8), .N_OUT(4), .ADDR_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .drop_count(drop_count)
   );

   stream_demux_router #(.WIDTH(8), .N_OUT(3), .ADDR_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_last(b_in_last), .in_addr(b_in_addr),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .busy(b_busy), .drop_count(b_drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_addr = '0; out_ready = 4'hF;
      b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_in_addr = '0; b_out_ready = 3'h7;
      #12;
      check("rst_out_valid", out_valid, 4'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_last", out_last, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_drop", drop_count, 8'd0);
      check("rst_b_drop", b_drop_count, 8'd0);
      rst_n = 1'b1;
      step();

      // 1: single-beat packet to output 2
      in_valid = 1'b1; in_addr = 2'd2; in_data = 8'hA5; in_last = 1'b1;
      #1;
      check("t1_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("t1_out_valid", out_valid, 4'b0100);
      check("t1_out_data2", out_data[23:16], 8'hA5);
      check("t1_out_last", out_last, 4'b0100);
      check("t1_busy", busy, 1'b0);
      step();
      check("t1_drained", out_valid, 4'b0000);

      // 2: 4-beat packet to output 1, later beats carry a misleading address
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_addr  = (i == 0) ? 2'd1 : 2'd3;
         in_data  = 8'h10 + 8'(i);
         in_last  = (i == 3);
         #1;
         check("t2_in_ready", in_ready, 1'b1);
         check("t2_busy", busy, (i != 0));
         step();
         check("t2_out_valid", out_valid, 4'b0010);
         check("t2_out_data1", out_data[15:8], 8'h10 + 8'(i));
         check("t2_out_last1", out_last[1], (i == 3));
      end
      in_valid = 1'b0;
      check("t2_busy_end", busy, 1'b0);
      step();
      check("t2_drained", out_valid, 4'b0000);

      // 3: output 0 stalled, then released
      out_ready = 4'b1110;
      in_valid = 1'b1; in_addr = 2'd0; in_data = 8'h20; in_last = 1'b0;
      #1;
      check("t3_ready_b0", in_ready, 1'b1);
      step();
      check("t3_valid_b0", out_valid, 4'b0001);
      check("t3_data_b0", out_data[7:0], 8'h20);
      in_data = 8'h21; in_addr = 2'd2;
      #1;
      check("t3_stall_ready", in_ready, 1'b0);
      step();
      step();
      check("t3_held_data", out_data[7:0], 8'h20);
      check("t3_held_valid", out_valid, 4'b0001);
      out_ready = 4'hF;
      #1;
      check("t3_resume_ready", in_ready, 1'b1);
      step();
      check("t3_data_b1", out_data[7:0], 8'h21);
      check("t3_last_b1", out_last[0], 1'b0);
      in_data = 8'h22; in_last = 1'b1;
      step();
      in_valid = 1'b0;
      check("t3_data_b2", out_data[7:0], 8'h22);
      check("t3_last_b2", out_last[0], 1'b1);
      check("t3_valid_b2", out_valid, 4'b0001);
      step();
      check("t3_drained", out_valid, 4'b0000);
      check("t3_busy", busy, 1'b0);

      // 4: bad address on the 3-output instance; later beats point at a real output
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1;
         b_in_addr  = (i == 0) ? 2'd3 : 2'd0;
         b_in_data  = 8'h30 + 8'(i);
         b_in_last  = (i == 2);
         #1;
         check("t4_in_ready", b_in_ready, 1'b1);
         step();
         check("t4_no_valid", b_out_valid, 3'b000);
         check("t4_drop", b_drop_count, 8'd1);
         check("t4_busy", b_busy, (i != 2));
      end
      b_in_addr = 2'd0; b_in_data = 8'h5C; b_in_last = 1'b1;
      step();
      b_in_valid = 1'b0;
      check("t4_next_valid", b_out_valid, 3'b001);
      check("t4_next_data", b_out_data[7:0], 8'h5C);
      check("t4_next_last", b_out_last, 3'b001);

      // 6: drop_count saturation
      b_in_valid = 1'b1; b_in_addr = 2'd3; b_in_last = 1'b1;
      for (int i = 0; i < 254; i++) step();
      check("t6_reach_255", b_drop_count, 8'd255);
      step();
      step();
      b_in_valid = 1'b0;
      check("t6_saturated", b_drop_count, 8'd255);
      check("t6_busy", b_busy, 1'b0);

      // 5: asynchronous reset mid-packet with a full slot
      out_ready = 4'b0111;
      in_valid = 1'b1; in_addr = 2'd3; in_data = 8'h40; in_last = 1'b0;
      step();
      check("t5_pre_busy", busy, 1'b1);
      check("t5_pre_valid", out_valid, 4'b1000);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", out_valid, 4'b0000);
      check("t5_async_busy", busy, 1'b0);
      check("t5_async_b_drop", b_drop_count, 8'd0);
      #1;
      rst_n = 1'b1;
      out_ready = 4'hF;
      step();
      in_valid = 1'b1; in_addr = 2'd2; in_data = 8'h77; in_last = 1'b1;
      step();
      in_valid = 1'b0;
      check("t5_head_valid", out_valid, 4'b0100);
      check("t5_head_data", out_data[23:16], 8'h77);
      check("t5_head_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
